noc_rr_output_arbiter: RTL and testbench

- Per-output-port scheduler for the 5-port NoC router.
- Shares one output link among the 5 input-port Fifo_buffer instances (16-bit flits) using round-robin arbitration with packet-level locking (wormhole).
- Drives the FIFO RD strobes, the crossbar select and the downstream write strobe, and honours the downstream FIFO full flag.
- One instance per output port; sits between the input FIFOs and the crossbar mux.

---
 rtl/noc_pkg.sv | 27 ++
 rtl/noc_rr_output_arbiter_rr_pick.sv | 35 +++
 rtl/noc_rr_output_arbiter.sv | 124 ++++++++++++
 tb/tb_noc_rr_output_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the 5-port NoC router.
//   N_PORTS     : number of router ports (and of input FIFOs per output port)
//   FLIT_W      : flit width in bits
//   port_e      : port index naming (LOCAL, NORTH, EAST, SOUTH, WEST)
//   arb_state_e : output arbiter state (IDLE, XFER)
// -----------------------------------------------------------------------------
package noc_pkg;

   localparam int N_PORTS = 5;
   localparam int FLIT_W  = 16;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      EAST  = 3'd2,
      SOUTH = 3'd3,
      WEST  = 3'd4
   } port_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

endpackage

// File: rtl/noc_rr_output_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational N-way round-robin priority encoder.
//   req    in  N      request vector
//   rr_ptr in  SEL_W  index with highest priority this round
//   idx    out SEL_W  first requesting index, searching rr_ptr, rr_ptr+1, ... mod N
//   valid  out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N     = 5,
   parameter int SEL_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] rr_ptr,
   output logic [SEL_W-1:0] idx,
   output logic             valid
);

   int cand;

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      // Walk offsets 0..N-1 from the pointer; the first hit wins.
      for (int k = 0; k < N; k++) begin
         cand = (int'(rr_ptr) + k) % N;
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = SEL_W'(cand);
         end
      end
   end

endmodule

// File: rtl/noc_rr_output_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_output_arbiter
// Per-output-port scheduler: shares one output link among N input FIFOs with
// round-robin arbitration and wormhole (packet-level) locking.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   req[i]    : input FIFO i non-empty and its head flit targets this port
//   tail[i]   : head flit of FIFO i is a packet tail
//   dn_full   : downstream FIFO full
//   rd        : one-hot pop strobe to the granted input FIFO
//   sel       : crossbar select (granted index)
//   wr_out    : downstream FIFO write strobe, coincident with rd
//   busy      : a packet is locked (state XFER)
//   pkt_cnt   : packets completed (wraps)
//   flit_cnt  : flits forwarded (wraps)
//   wdog_err  : sticky, set when a packet exceeds MAX_FLITS and is force-released
// Handshake: a flit moves exactly in the cycle where rd[g] (= wr_out) is high;
// that requires the grant locked, req[g]=1 and dn_full=0. Nothing is buffered.
// -----------------------------------------------------------------------------
module noc_rr_output_arbiter
   import noc_pkg::*;
#(
   parameter int N         = N_PORTS,
   parameter int SEL_W     = 3,
   parameter int MAX_FLITS = 16,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     tail,
   input  logic             dn_full,
   output logic [N-1:0]     rd,
   output logic [SEL_W-1:0] sel,
   output logic             wr_out,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] flit_cnt,
   output logic             wdog_err
);

   localparam int BEAT_W = $clog2(MAX_FLITS + 1);

   arb_state_e        state;
   logic [SEL_W-1:0]  grant;
   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  next_ptr;
   logic [SEL_W-1:0]  pick_idx;
   logic              pick_valid;
   logic [BEAT_W-1:0] beats;
   logic              pop;
   logic              tail_pop;
   logic              wdog_hit;

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   // Pop strobe is combinational from the registered grant; gated by rst so a
   // reset arriving mid-packet never pops a flit in the reset cycle.
   always_comb begin
      rd = '0;
      if (state == XFER && !rst && !dn_full)
         rd[grant] = req[grant];
   end

   assign pop      = |rd;
   assign wr_out   = pop;
   assign sel      = grant;
   assign busy     = (state == XFER);
   assign tail_pop = pop & tail[grant];
   // beats counts pops already taken, so this pop is number MAX_FLITS.
   assign wdog_hit = pop & ~tail[grant] & (beats == BEAT_W'(MAX_FLITS - 1));
   assign next_ptr = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         beats    <= '0;
         pkt_cnt  <= '0;
         flit_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant <= pick_idx;
                  beats <= '0;
                  state <= XFER;
               end
            end
            XFER: begin
               if (pop) begin
                  flit_cnt <= flit_cnt + CNT_W'(1);
                  if (tail_pop) begin
                     pkt_cnt <= pkt_cnt + CNT_W'(1);
                     rr_ptr  <= next_ptr;
                     beats   <= '0;
                     state   <= IDLE;
                  end else if (wdog_hit) begin
                     wdog_err <= 1'b1;
                     rr_ptr   <= next_ptr;
                     beats    <= '0;
                     state    <= IDLE;
                  end else begin
                     beats <= beats + BEAT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_rd_onehot: assert property (@(posedge clk) $onehot0(rd));

endmodule

// File: tb/tb_noc_rr_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_rr_output_arbiter
// Self-checking bench for noc_rr_output_arbiter: a directed vector table, hand
// written multi-cycle sequences, and a randomized run, all compared each cycle
// against a packet-level reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_noc_rr_output_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] req;
   logic [4:0] tail;
   logic       dn_full;
   logic [4:0] rd;
   logic [2:0] sel;
   logic       wr_out;
   logic       busy;
   logic [15:0] pkt_cnt;
   logic [15:0] flit_cnt;
   logic       wdog_err;

   noc_rr_output_arbiter #(
      .N(5), .SEL_W(3), .MAX_FLITS(16), .CNT_W(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .tail     (tail),
      .dn_full  (dn_full),
      .rd       (rd),
      .sel      (sel),
      .wr_out   (wr_out),
      .busy     (busy),
      .pkt_cnt  (pkt_cnt),
      .flit_cnt (flit_cnt),
      .wdog_err (wdog_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within limit");
      $fatal(1, "timeout");
   end

   // ---------------- counters / check ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Packet-level view: either nobody owns the link, or one port owns it
   // until its tail flit leaves (or 16 flits leave without a tail).
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_beats;
   int m_pkt;
   int m_flit;
   bit m_wdog;

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
      m_pkt = 0; m_flit = 0; m_wdog = 0;
   endtask

   // ---------------- scoreboard for grant order ----------------
   logic [2:0] exp_q[$];
   bit sb_on = 0;

   // One clock cycle: drive at negedge, check just after, then advance.
   task automatic step(input logic r, input logic [4:0] q, input logic [4:0] t, input logic f);
      logic [4:0] e_rd;
      int gi;
      int found;
      rst = r; req = q; tail = t; dn_full = f;
      #1;
      e_rd = '0;
      if (!r && m_busy && q[m_owner] && !f) e_rd[m_owner] = 1'b1;
      chk("rd", rd, e_rd);
      chk("wr_out", wr_out, |e_rd);
      chk("sel", sel, m_owner);
      chk("busy", busy, m_busy);
      chk("pkt_cnt", pkt_cnt, m_pkt % 65536);
      chk("flit_cnt", flit_cnt, m_flit % 65536);
      chk("wdog_err", wdog_err, m_wdog);
      if (sb_on && rd != '0) begin
         gi = 0;
         for (int i = 0; i < 5; i++) if (rd[i]) gi = i;
         if (exp_q.size() == 0) chk("sb_extra_grant", rd, 0);
         else chk("sb_grant", gi, exp_q.pop_front());
      end
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (!m_busy) begin
         found = 0;
         for (int k = 0; k < 5; k++) begin
            if (!found && q[(m_ptr + k) % 5]) begin
               found = 1;
               m_owner = (m_ptr + k) % 5;
            end
         end
         if (found) begin m_busy = 1; m_beats = 0; end
      end else if (e_rd != '0) begin
         m_flit++;
         m_beats++;
         if (t[m_owner]) begin
            m_pkt++; m_ptr = (m_owner + 1) % 5; m_beats = 0; m_busy = 0;
         end else if (m_beats == 16) begin
            m_wdog = 1; m_ptr = (m_owner + 1) % 5; m_beats = 0; m_busy = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1; req = '0; tail = '0; dn_full = 0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [4:0]  req;
      logic [4:0]  tail;
      logic        full;
      logic [4:0]  rd;
      logic [2:0]  sel;
      logic        busy;
      logic [15:0] pkt;
      logic [15:0] flit;
   } vec_t;

   vec_t tv[14];

   initial begin
      logic [4:0] t;
      rst = 1; req = '0; tail = '0; dn_full = 0;
      model_reset();
      @(negedge clk);

      // Single-flit packet from port 0, then all ports with single-flit packets.
      tv[0]  = '{5'b00001, 5'b11111, 1'b0, 5'b00000, 3'd0, 1'b0, 16'd0, 16'd0};
      tv[1]  = '{5'b00001, 5'b11111, 1'b0, 5'b00001, 3'd0, 1'b1, 16'd0, 16'd0};
      tv[2]  = '{5'b00000, 5'b11111, 1'b0, 5'b00000, 3'd0, 1'b0, 16'd1, 16'd1};
      tv[3]  = '{5'b11111, 5'b11111, 1'b0, 5'b00000, 3'd0, 1'b0, 16'd1, 16'd1};
      tv[4]  = '{5'b11111, 5'b11111, 1'b0, 5'b00010, 3'd1, 1'b1, 16'd1, 16'd1};
      tv[5]  = '{5'b11111, 5'b11111, 1'b0, 5'b00000, 3'd1, 1'b0, 16'd2, 16'd2};
      tv[6]  = '{5'b11111, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 16'd2, 16'd2};
      tv[7]  = '{5'b11111, 5'b11111, 1'b0, 5'b00000, 3'd2, 1'b0, 16'd3, 16'd3};
      tv[8]  = '{5'b11111, 5'b11111, 1'b0, 5'b01000, 3'd3, 1'b1, 16'd3, 16'd3};
      tv[9]  = '{5'b11111, 5'b11111, 1'b0, 5'b00000, 3'd3, 1'b0, 16'd4, 16'd4};
      tv[10] = '{5'b11111, 5'b11111, 1'b0, 5'b10000, 3'd4, 1'b1, 16'd4, 16'd4};
      tv[11] = '{5'b11111, 5'b11111, 1'b0, 5'b00000, 3'd4, 1'b0, 16'd5, 16'd5};
      tv[12] = '{5'b11111, 5'b11111, 1'b0, 5'b00001, 3'd0, 1'b1, 16'd5, 16'd5};
      tv[13] = '{5'b00000, 5'b11111, 1'b0, 5'b00000, 3'd0, 1'b0, 16'd6, 16'd6};

      do_reset();
      chk("reset_wdog", wdog_err, 0);
      for (int i = 0; i < 14; i++) begin
         rst = 0; req = tv[i].req; tail = tv[i].tail; dn_full = tv[i].full;
         #1;
         chk("tv_rd", rd, tv[i].rd);
         chk("tv_wr", wr_out, |tv[i].rd);
         chk("tv_sel", sel, tv[i].sel);
         chk("tv_busy", busy, tv[i].busy);
         chk("tv_pkt", pkt_cnt, tv[i].pkt);
         chk("tv_flit", flit_cnt, tv[i].flit);
         step(0, tv[i].req, tv[i].tail, tv[i].full);
      end

      // Full rotation from reset: grants 0,1,2,3,4,0.
      do_reset();
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      sb_on = 1;
      for (int i = 0; i < 10; i++) step(0, 5'b11111, 5'b11111, 0);
      chk("rot_pkt_after_10", pkt_cnt, 5);
      for (int i = 0; i < 2; i++) step(0, 5'b11111, 5'b11111, 0);
      sb_on = 0;
      chk("rot_sb_empty", exp_q.size(), 0);

      // 4-flit packet on port 2 while port 3 keeps requesting.
      do_reset();
      step(0, 5'b01100, 5'b01000, 0);
      for (int k = 1; k <= 4; k++) begin
         t = 5'b01000;
         if (k == 4) t[2] = 1'b1;
         step(0, 5'b01100, t, 0);
         if (k < 4) chk("wh_locked_sel", sel, 2);
      end
      chk("wh_flit_before_p3", flit_cnt, 4);
      chk("wh_released", busy, 0);
      step(0, 5'b01000, 5'b01000, 0);
      chk("wh_p3_sel", sel, 3);
      step(0, 5'b01000, 5'b01000, 0);
      chk("wh_p3_flit", flit_cnt, 5);

      // Backpressure on port 1 for 3 cycles mid-packet.
      do_reset();
      step(0, 5'b00010, 5'b00000, 0);
      step(0, 5'b00010, 5'b00000, 0);
      for (int k = 0; k < 3; k++) begin
         rst = 0; req = 5'b00010; tail = 5'b00000; dn_full = 1; #1;
         chk("bp_rd", rd, 0);
         chk("bp_wr", wr_out, 0);
         chk("bp_sel", sel, 1);
         step(0, 5'b00010, 5'b00000, 1);
      end
      step(0, 5'b00010, 5'b00000, 0);
      step(0, 5'b00010, 5'b00010, 0);
      chk("bp_flit", flit_cnt, 3);
      chk("bp_pkt", pkt_cnt, 1);

      // Watchdog: port 4 streams 16 flits with no tail.
      do_reset();
      step(0, 5'b10000, 5'b00000, 0);
      for (int k = 0; k < 16; k++) begin
         if (k == 15) chk("wd_not_yet", wdog_err, 0);
         step(0, 5'b10000, 5'b00000, 0);
      end
      chk("wd_err", wdog_err, 1);
      chk("wd_idle", busy, 0);
      chk("wd_pkt", pkt_cnt, 0);
      chk("wd_flit", flit_cnt, 16);
      step(0, 5'b10001, 5'b11111, 0);
      chk("wd_ptr_wrap_sel", sel, 0);
      step(0, 5'b10001, 5'b11111, 0);
      chk("wd_sticky", wdog_err, 1);

      // Reset in the middle of a 3-flit packet on port 2.
      do_reset();
      step(0, 5'b00100, 5'b00000, 0);
      step(0, 5'b00100, 5'b00000, 0);
      rst = 1; req = 5'b00100; tail = 5'b00000; dn_full = 0; #1;
      chk("rst_mid_rd", rd, 0);
      chk("rst_mid_wr", wr_out, 0);
      step(1, 5'b00100, 5'b00000, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sel", sel, 0);
      chk("rst_pkt", pkt_cnt, 0);
      chk("rst_flit", flit_cnt, 0);
      chk("rst_wdog", wdog_err, 0);
      step(0, 5'b00101, 5'b00101, 0);
      step(0, 5'b00101, 5'b00101, 0);
      chk("rst_restart_flit", flit_cnt, 1);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 59) == 0),
              5'($urandom_range(0, 31)),
              5'($urandom) & 5'($urandom),
              ($urandom_range(0, 3) == 0));
      end
      // Long no-tail stream to exercise the watchdog under random backpressure.
      do_reset();
      for (int i = 0; i < 60; i++) step(0, 5'b00100, 5'b00000, ($urandom_range(0, 2) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
